pipeline_vertex_sched: RTL and testbench

//  Sequencer for the vertex-transform pipeline: owns its camera, rotation, scale and translation

---
 rtl/pipeline_vertex_sched.sv | 136 +++++++++++++
 tb/tb_pipeline_vertex_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_vertex_sched.sv
// Vertex-transform pipeline sequencer: issues vertices, tracks the fixed pipeline latency,
// captures results into a credit-reserved FIFO and applies double-buffered config when drained.
module pipeline_vertex_sched #(
  parameter int DATA_W       = 16,
  parameter int PIPE_LATENCY = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [DATA_W-1:0]    cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  input  logic                 vin_valid,
  output logic                 vin_ready,
  input  logic [DATA_W-1:0]    vin_x,
  input  logic [DATA_W-1:0]    vin_y,
  input  logic [DATA_W-1:0]    vin_z,
  output logic [16*DATA_W-1:0] pipe_cfg,
  output logic [DATA_W-1:0]    pipe_vx,
  output logic [DATA_W-1:0]    pipe_vy,
  output logic [DATA_W-1:0]    pipe_vz,
  output logic                 pipe_issue,
  input  logic [DATA_W-1:0]    pipe_out_x,
  input  logic [DATA_W-1:0]    pipe_out_y,
  input  logic [DATA_W-1:0]    pipe_out_exc,
  output logic                 vout_valid,
  input  logic                 vout_ready,
  output logic [DATA_W-1:0]    vout_x,
  output logic [DATA_W-1:0]    vout_y,
  output logic [DATA_W-1:0]    vout_exc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CFG} state_t;

  state_t                  state;
  logic                    commit_pending;
  logic [16*DATA_W-1:0]    shadow;
  logic [16*DATA_W-1:0]    active;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          credit_used;
  logic [PIPE_LATENCY-1:0] valid_sr;
  logic [3*DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    accept;
  logic                    push;
  logic                    pop;

  // Credit covers both results still in the pipeline and results parked in the FIFO.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign vin_ready   = (state == IDLE || state == RUN) && !commit_pending && (credit_used < DEPTH_LIM);
  assign accept      = vin_valid && vin_ready;
  assign push        = valid_sr[PIPE_LATENCY-1];
  assign vout_valid  = (fifo_count != '0);
  assign pop         = vout_valid && vout_ready;
  assign {vout_exc, vout_y, vout_x} = fifo_mem[rd_ptr];
  assign pipe_cfg    = active;
  assign cfg_busy    = commit_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      shadow         <= '0;
      active         <= '0;
      pipe_vx        <= '0;
      pipe_vy        <= '0;
      pipe_vz        <= '0;
      pipe_issue     <= 1'b0;
      inflight       <= '0;
      valid_sr       <= '0;
    end else begin
      pipe_issue <= accept;
      if (accept) begin
        pipe_vx <= vin_x;
        pipe_vy <= vin_y;
        pipe_vz <= vin_z;
      end
      valid_sr <= (valid_sr << 1) | PIPE_LATENCY'(pipe_issue);
      inflight <= inflight + CNT_W'(accept) - CNT_W'(push);
      if (cfg_we) shadow[DATA_W*cfg_addr +: DATA_W] <= cfg_wdata;

      // A commit arriving during the CFG cycle re-arms for the next copy.
      if (state == CFG)    commit_pending <= cfg_commit;
      else if (cfg_commit) commit_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (commit_pending) state <= DRAIN;
          else if (accept)    state <= RUN;
        end
        RUN: begin
          if (commit_pending)                  state <= DRAIN;
          else if (inflight == '0 && !accept)  state <= IDLE;
        end
        DRAIN: begin
          if (inflight == '0) state <= CFG;
        end
        CFG: begin
          active <= shadow;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {pipe_out_exc, pipe_out_y, pipe_out_x};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Credit reservation at accept makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == DEPTH_CNT))
    else $error("result FIFO overflow");

endmodule

// File: tb/tb_pipeline_vertex_sched.sv
// Bench for pipeline_vertex_sched: stub latency pipeline, vector table, scoreboard of expected results.
module tb_pipeline_vertex_sched;
  localparam int DW = 16;
  localparam int L  = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, cfg_we, cfg_commit, cfg_busy;
  logic [3:0]     cfg_addr;
  logic [DW-1:0]  cfg_wdata;
  logic           vin_valid, vin_ready;
  logic [DW-1:0]  vin_x, vin_y, vin_z;
  logic [16*DW-1:0] pipe_cfg;
  logic [DW-1:0]  pipe_vx, pipe_vy, pipe_vz;
  logic           pipe_issue;
  logic [DW-1:0]  pipe_out_x, pipe_out_y, pipe_out_exc;
  logic           vout_valid, vout_ready;
  logic [DW-1:0]  vout_x, vout_y, vout_exc;
  logic           exc_en;

  pipeline_vertex_sched #(.DATA_W(DW), .PIPE_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vin_x(vin_x), .vin_y(vin_y), .vin_z(vin_z), .pipe_cfg(pipe_cfg),
    .pipe_vx(pipe_vx), .pipe_vy(pipe_vy), .pipe_vz(pipe_vz), .pipe_issue(pipe_issue),
    .pipe_out_x(pipe_out_x), .pipe_out_y(pipe_out_y), .pipe_out_exc(pipe_out_exc),
    .vout_valid(vout_valid), .vout_ready(vout_ready),
    .vout_x(vout_x), .vout_y(vout_y), .vout_exc(vout_exc)
  );

  // Stub pipeline: fixed L-cycle delay line; junk values when no valid result emerges.
  logic [3*DW:0] dl [L];
  always @(posedge clk) begin
    for (int i = L-1; i > 0; i--) dl[i] <= dl[i-1];
    dl[0] <= {pipe_issue, pipe_vz, pipe_vy, pipe_vx};
  end
  assign pipe_out_x   = dl[L-1][3*DW] ? dl[L-1][DW-1:0] + 16'd1      : 16'hDEAD;
  assign pipe_out_y   = dl[L-1][3*DW] ? dl[L-1][2*DW-1:DW] + 16'd1   : 16'hBEEF;
  assign pipe_out_exc = dl[L-1][3*DW] ? (exc_en ? dl[L-1][3*DW-1:2*DW] : 16'd0) : 16'hF00D;

  typedef struct packed { logic [DW-1:0] e, y, x; } res_t;
  typedef struct { logic [DW-1:0] x, y, z; logic exc_en; logic [DW-1:0] ex, ey, ee; } vec_t;

  res_t sb[$];
  vec_t vecs[4];
  int errors = 0, checks = 0, acc_cnt = 0, pop_cnt = 0;
  logic [16*DW-1:0] exp_cfg = '0;

  task automatic check(input string name, input logic [16*DW-1:0] act, input logic [16*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    res_t r;
    if (!rst) begin
      if (vin_valid && vin_ready) begin
        sb.push_back({exc_en ? vin_z : 16'd0, vin_y + 16'd1, vin_x + 16'd1});
        acc_cnt++;
        check("credit_outstanding", sb.size() <= D, 1);
      end
      if (pipe_issue) check("cfg_at_issue", pipe_cfg, exp_cfg);
      if (vout_valid && vout_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got result %0h expected none", {vout_exc, vout_y, vout_x});
        end else begin
          r = sb.pop_front();
          check("vout_data", {vout_exc, vout_y, vout_x}, r);
          pop_cnt++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vertex(input int k);
    vin_x = 16'(k*5 + 3);
    vin_y = 16'(k*11);
    vin_z = 16'(k ^ 'h55);
  endtask

  task automatic drain(input int bound);
    int g;
    g = 0;
    while (sb.size() != 0 && g < bound) begin tick(); g++; end
    check("drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, pbase, idx, viol;
    logic low_seen;
    vecs[0] = '{16'd1,     16'd2,     16'd3,     1'b0, 16'd2,     16'd3,     16'd0};
    vecs[1] = '{16'hFFFF,  16'h0000,  16'h0005,  1'b1, 16'h0000,  16'h0001,  16'h0005};
    vecs[2] = '{16'd100,   16'd200,   16'd300,   1'b1, 16'd101,   16'd201,   16'd300};
    vecs[3] = '{16'h7FFF,  16'h8000,  16'hA5A5,  1'b1, 16'h8000,  16'h8001,  16'hA5A5};

    rst = 1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
    vin_valid = 0; vin_x = 0; vin_y = 0; vin_z = 0; vout_ready = 1; exc_en = 0;
    tick(); tick();
    rst = 0;
    check("rst_vout_valid", vout_valid, 0);
    check("rst_pipe_issue", pipe_issue, 0);
    check("rst_pipe_cfg", pipe_cfg, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    check("rst_vin_ready", vin_ready, 1);

    // Single vertices: issue timing, latency and data.
    for (int i = 0; i < 4; i++) begin
      exc_en = vecs[i].exc_en;
      vin_x = vecs[i].x; vin_y = vecs[i].y; vin_z = vecs[i].z; vin_valid = 1;
      check("vin_ready_idle", vin_ready, 1);
      tick();
      vin_valid = 0;
      check("issue_after_accept", pipe_issue, 1);
      check("pipe_vertex", {pipe_vz, pipe_vy, pipe_vx}, {vecs[i].z, vecs[i].y, vecs[i].x});
      tick();
      check("issue_one_cycle", pipe_issue, 0);
      n = 1;
      while (!vout_valid && n < 40) begin tick(); n++; end
      check("latency", n, L+1);
      check("vout_vec", {vout_exc, vout_y, vout_x}, {vecs[i].ee, vecs[i].ey, vecs[i].ex});
      tick();
      check("vout_popped", vout_valid, 0);
    end

    // Stream of 20 with consumer always ready.
    exc_en = 1; vout_ready = 1; base = acc_cnt; pbase = pop_cnt; idx = 0; n = 0; low_seen = 0;
    while ((acc_cnt - base) < 20 && n < 1000) begin
      drive_vertex(idx); vin_valid = 1;
      if (!vin_ready) low_seen = 1;
      tick(); n++;
      idx = acc_cnt - base;
    end
    vin_valid = 0;
    drain(200);
    check("stream_accepted", acc_cnt - base, 20);
    check("stream_results", pop_cnt - pbase, 20);
    check("stream_throttle", low_seen, 1);

    // Consumer stalled: only D accepts, then release.
    vout_ready = 0; base = acc_cnt; pbase = pop_cnt;
    for (int c = 0; c < 30; c++) begin
      drive_vertex(100 + acc_cnt - base);
      vin_valid = ((acc_cnt - base) < 10);
      tick();
    end
    check("held_accepts", acc_cnt - base, D);
    check("held_ready_low", vin_ready, 0);
    check("held_vout_valid", vout_valid, 1);
    vout_ready = 1; n = 0;
    while ((acc_cnt - base) < 10 && n < 500) begin
      drive_vertex(100 + acc_cnt - base); vin_valid = 1;
      tick(); n++;
    end
    vin_valid = 0;
    drain(200);
    check("release_accepted", acc_cnt - base, 10);
    check("release_results", pop_cnt - pbase, 10);

    // Commit with 3 in flight.
    cfg_we = 1; cfg_addr = 4'd10; cfg_wdata = 16'h0200;
    tick();
    cfg_we = 0;
    for (int k = 0; k < 3; k++) begin drive_vertex(200 + k); vin_valid = 1; tick(); end
    vin_valid = 0; cfg_commit = 1;
    tick();
    cfg_commit = 0; drive_vertex(300); vin_valid = 1;
    check("busy_after_commit", cfg_busy, 1);
    check("ready_during_drain", vin_ready, 0);
    base = acc_cnt; viol = 0; n = 0;
    while (cfg_busy && n < 50) begin
      if (pipe_cfg !== exp_cfg) viol++;
      if (vin_ready) viol++;
      tick(); n++;
    end
    check("cfg_stable_drain", viol, 0);
    check("no_accept_drain", acc_cnt - base, 0);
    check("busy_fell", cfg_busy, 0);
    check("word10_applied", pipe_cfg[10*DW +: DW], 16'h0200);
    exp_cfg[10*DW +: DW] = 16'h0200;
    tick();
    vin_valid = 0;
    drain(100);

    // Accept together with commit, plus a write during the CFG cycle.
    cfg_we = 1; cfg_addr = 4'd13; cfg_wdata = 16'h1234;
    tick();
    cfg_we = 0;
    drive_vertex(400); vin_valid = 1; cfg_commit = 1; base = acc_cnt;
    check("ready_with_commit", vin_ready, 1);
    tick();
    vin_valid = 0; cfg_commit = 0;
    check("accept_with_commit", acc_cnt - base, 1);
    check("issue_old_word13", pipe_cfg[13*DW +: DW], 16'h0000);
    repeat (L+2) tick();
    check("busy_in_cfg", cfg_busy, 1);
    cfg_we = 1; cfg_addr = 4'd14; cfg_wdata = 16'h7777;
    tick();
    cfg_we = 0;
    check("busy_fall_timing", cfg_busy, 0);
    check("word13_applied", pipe_cfg[13*DW +: DW], 16'h1234);
    check("word14_not_applied", pipe_cfg[14*DW +: DW], 16'h0000);
    exp_cfg[13*DW +: DW] = 16'h1234;
    cfg_commit = 1;
    tick();
    cfg_commit = 0; n = 0;
    while (cfg_busy && n < 50) begin tick(); n++; end
    check("word14_second_commit", pipe_cfg[14*DW +: DW], 16'h7777);
    exp_cfg[14*DW +: DW] = 16'h7777;
    drain(100);

    // Reset with 2 results in the FIFO and 2 in flight.
    vout_ready = 0;
    for (int k = 0; k < 2; k++) begin drive_vertex(500 + k); vin_valid = 1; tick(); end
    vin_valid = 0;
    repeat (L+4) tick();
    check("fifo_holds", vout_valid, 1);
    for (int k = 0; k < 2; k++) begin drive_vertex(600 + k); vin_valid = 1; tick(); end
    vin_valid = 0; rst = 1;
    sb.delete();
    tick();
    rst = 0; exp_cfg = '0;
    check("midrst_vout_valid", vout_valid, 0);
    check("midrst_pipe_issue", pipe_issue, 0);
    check("midrst_pipe_cfg", pipe_cfg, 0);
    check("midrst_vin_ready", vin_ready, 1);
    check("midrst_cfg_busy", cfg_busy, 0);
    vout_ready = 1; viol = 0;
    repeat (L+6) begin
      if (vout_valid) viol++;
      tick();
    end
    check("midrst_discard", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
